monopix_rx_core: RTL and testbench

Chip-side readout controller in the FPGA firmware. Watches the MONOPIX `TOKEN` output and runs the `FREEZE`/`READ` handshake. Deserializes hit words from `DATA` while gating `CLK_OUT`, and pushes 32-bit tagged words toward the FIFO/SRAM path with valid/ready flow control. It sits directly between the chip readout pins and the data FIFO inside `monopix_mio`.

---
 rtl/monopix_rx_pkg.sv | 27 ++
 rtl/monopix_rx_outbuf.sv | 65 ++++++
 rtl/monopix_rx_core.sv | 129 ++++++++++++
 tb/tb_monopix_rx_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monopix_rx_pkg.sv
// Shared types and hit-word field layout for the MONOPIX readout controller.
package monopix_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FREEZE_WAIT,
      ST_READ_PULSE,
      ST_SHIFT,
      ST_CHECK,
      ST_HOLD
   } rx_state_t;

   // Hit word layout, MSB first on the wire: {COL, ROW, LE, TE}
   localparam int COL_W    = 6;
   localparam int ROW_W    = 8;
   localparam int LE_W     = 6;
   localparam int TE_W     = 6;
   localparam int TE_OFF   = 0;
   localparam int LE_OFF   = TE_OFF + TE_W;
   localparam int ROW_OFF  = LE_OFF + LE_W;
   localparam int COL_OFF  = ROW_OFF + ROW_W;
   localparam int HIT_BITS = COL_OFF + COL_W;

   // Width of the shared phase counter; must hold the longest phase length
   localparam int CNT_W    = 8;

endpackage

// File: rtl/monopix_rx_outbuf.sv
// Two-entry skid buffer between the deserializer and the FIFO path.
// Pushes never stall; a push into a full buffer is dropped and counted,
// unless a pop happens in the same cycle and frees a slot.
module monopix_rx_outbuf
   import monopix_rx_pkg::*;
#(
   parameter int DATA_BITS = HIT_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_push,
   input  logic [DATA_BITS-1:0] i_push_data,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [DATA_BITS-1:0] o_data,
   output logic [7:0]           o_lost_cnt
);

   logic [DATA_BITS-1:0] r_slot0;
   logic [DATA_BITS-1:0] r_slot1;
   logic [1:0]           r_count;
   logic [7:0]           r_lost;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_drop;
   logic [1:0]           w_count_after_pop;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_pop             = (r_count != 2'd0) && i_ready;
   assign w_count_after_pop = r_count - {1'b0, w_pop};
   assign w_accept          = i_push && (w_count_after_pop != 2'd2);
   assign w_drop            = i_push && !w_accept;

   // Occupancy and saturating drop counter
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_count <= 2'd0;
         r_lost  <= 8'd0;
      end else begin
         r_count <= w_count_after_pop + {1'b0, w_accept};
         if (w_drop)
            r_lost <= sat_inc(r_lost);
      end
   end

   // Data slots, head of line in slot0; a push landing in an emptied slot0 overrides the shift
   always_ff @(posedge i_clk) begin
      if (w_pop)
         r_slot0 <= r_slot1;
      if (w_accept) begin
         if (w_count_after_pop == 2'd0)
            r_slot0 <= i_push_data;
         else
            r_slot1 <= i_push_data;
      end
   end

   assign o_valid    = (r_count != 2'd0);
   assign o_data     = r_slot0;
   assign o_lost_cnt = r_lost;

endmodule

// File: rtl/monopix_rx_core.sv
// MONOPIX chip-side readout: TOKEN-triggered FREEZE/READ handshake, serial
// deserialization of hit words while CLK_OUT is gated on, tagged output words.
module monopix_rx_core
   import monopix_rx_pkg::*;
#(
   parameter logic [3:0] IDENTIFIER   = 4'b0001,
   parameter int         DATA_BITS    = 26,
   parameter int         FREEZE_SETUP = 2,
   parameter int         READ_LEN     = 2,
   parameter int         FREEZE_HOLD  = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ENABLE,
   input  logic        TOKEN,
   input  logic        DATA,
   output logic        FREEZE,
   output logic        READ,
   output logic        CLK_OUT_EN,
   output logic [31:0] DATA_OUT,
   output logic        DATA_VALID,
   input  logic        DATA_READY,
   output logic [7:0]  LOST_CNT,
   output logic        BUSY
);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(FREEZE_SETUP - 1);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_LEN - 1);
   localparam logic [CNT_W-1:0] BITS_LAST  = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FREEZE_HOLD - 1);

   rx_state_t            r_state;
   rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [DATA_BITS-2:0] r_shift;
   logic                 w_push;
   logic [DATA_BITS-1:0] w_word;
   logic [DATA_BITS-1:0] w_hit;
   logic                 w_valid;

   // State and phase counter; reset drops straight back to IDLE
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; the word is pushed on the edge that captures its last bit
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (ENABLE && TOKEN)
               w_state_nxt = ST_FREEZE_WAIT;
         end
         ST_FREEZE_WAIT: begin
            if (r_cnt == SETUP_LAST) begin
               w_state_nxt = ST_READ_PULSE;
               w_cnt_nxt   = '0;
            end
         end
         ST_READ_PULSE: begin
            if (r_cnt == READ_LAST) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = '0;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == BITS_LAST) begin
               w_state_nxt = ST_CHECK;
               w_cnt_nxt   = '0;
               w_push      = 1'b1;
            end
         end
         ST_CHECK: begin
            w_cnt_nxt   = '0;
            w_state_nxt = TOKEN ? ST_READ_PULSE : ST_HOLD;
         end
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Serial capture, MSB first; only the first DATA_BITS-1 bits need storing
   always_ff @(posedge CLK) begin
      if (r_state == ST_SHIFT)
         r_shift <= {r_shift[DATA_BITS-3:0], DATA};
   end

   assign w_word     = {r_shift, DATA};

   assign FREEZE     = (r_state != ST_IDLE);
   assign BUSY       = (r_state != ST_IDLE);
   assign READ       = (r_state == ST_READ_PULSE);
   assign CLK_OUT_EN = (r_state == ST_SHIFT);

   monopix_rx_outbuf #(
      .DATA_BITS (DATA_BITS)
   ) u_outbuf (
      .i_clk       (CLK),
      .i_nrst      (nRST),
      .i_push      (w_push),
      .i_push_data (w_word),
      .i_ready     (DATA_READY),
      .o_valid     (w_valid),
      .o_data      (w_hit),
      .o_lost_cnt  (LOST_CNT)
   );

   assign DATA_VALID = w_valid;
   assign DATA_OUT   = w_valid ? {IDENTIFIER, 2'b00, w_hit} : 32'h0;

endmodule

// File: tb/tb_monopix_rx_core.sv
// Bench for monopix_rx_core: chip model driving DATA, queue-based reference
// for the output buffer, table-driven single readouts and corner sequences.
module tb_monopix_rx_core;

   localparam int         DB = 26;
   localparam int         FS = 2;
   localparam int         RL = 2;
   localparam int         FH = 2;
   localparam logic [3:0] ID = 4'b0001;

   localparam int WORD_CYC  = RL + DB + 1;
   localparam int FIRST_CHK = 1 + FS + RL + DB;
   localparam int ONE_TOTAL = 1 + FS + RL + DB + 1 + FH;

   logic        CLK = 1'b0;
   logic        nRST, ENABLE, TOKEN, DATA, DATA_READY;
   logic        FREEZE, READ, CLK_OUT_EN, DATA_VALID, BUSY;
   logic [31:0] DATA_OUT;
   logic [7:0]  LOST_CNT;

   always #5 CLK = ~CLK;

   monopix_rx_core #(
      .IDENTIFIER   (ID),
      .DATA_BITS    (DB),
      .FREEZE_SETUP (FS),
      .READ_LEN     (RL),
      .FREEZE_HOLD  (FH)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .ENABLE     (ENABLE),
      .TOKEN      (TOKEN),
      .DATA       (DATA),
      .FREEZE     (FREEZE),
      .READ       (READ),
      .CLK_OUT_EN (CLK_OUT_EN),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .LOST_CNT   (LOST_CNT),
      .BUSY       (BUSY)
   );

   typedef struct {
      logic [25:0] hit;
      logic [31:0] exp_out;
   } vec_t;

   typedef struct {
      int total;
      int fc;
      int rc;
      int pulses;
      int first_read;
      int cc;
      int first_valid;
   } meas_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [25:0] words[$];
   int          chip_rd = 0;
   int          bitidx  = 0;
   logic [25:0] cur     = '0;
   logic [25:0] mq[$];
   int          mlost   = 0;
   logic [31:0] got_q[$];
   bit          mon_on  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: at the falling edge check outputs against the reference queue,
   // play the chip's serial output and advance the reference; return after the rising edge.
   task automatic step();
      logic        push_evt;
      logic [31:0] exp_out;
      push_evt = 1'b0;
      @(negedge CLK);
      if (mon_on) begin
         exp_out = 32'h0;
         if (mq.size() != 0) exp_out = {ID, 2'b00, mq[0]};
         chk("mon_valid", 32'(DATA_VALID), 32'(mq.size() != 0));
         chk("mon_data", DATA_OUT, exp_out);
         chk("mon_lost", 32'(LOST_CNT), 32'(mlost));
      end
      if (DATA_VALID === 1'b1 && DATA_READY) got_q.push_back(DATA_OUT);
      if (CLK_OUT_EN === 1'b1) begin
         if (bitidx == 0) begin
            cur = (chip_rd < words.size()) ? words[chip_rd] : 26'h0;
            chip_rd++;
         end
         DATA     = cur[DB-1-bitidx];
         push_evt = (bitidx == DB - 1);
         bitidx   = push_evt ? 0 : bitidx + 1;
      end else begin
         DATA = 1'($urandom_range(0, 1));
      end
      if (!nRST) begin
         mq.delete();
         mlost  = 0;
         bitidx = 0;
      end else begin
         if (DATA_READY && mq.size() != 0) void'(mq.pop_front());
         if (push_evt) begin
            if (mq.size() < 2) mq.push_back(cur);
            else if (mlost < 255) mlost++;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      step();
      step();
      nRST = 1'b1;
   endtask

   // Run one readout of nw words (TOKEN held until the last CHECK) and profile the outputs.
   task automatic measure(input int nw, input int en_drop, input bit rnd_rdy,
                          input int limit, output meas_t m);
      int k;
      bit prev_read;
      k = 0;
      prev_read = 1'b0;
      m = '{default: 0};
      m.first_read  = -1;
      m.first_valid = -1;
      forever begin
         TOKEN = (k < FIRST_CHK + (nw - 1) * WORD_CYC);
         if (en_drop >= 0 && k >= en_drop) ENABLE = 1'b0;
         if (rnd_rdy) DATA_READY = ($urandom_range(0, 2) != 0);
         if (k > 0 && !BUSY) break;
         if (k >= limit) break;
         if (FREEZE) m.fc++;
         if (READ) m.rc++;
         if (READ && !prev_read) begin
            m.pulses++;
            if (m.first_read < 0) m.first_read = k;
         end
         prev_read = READ;
         if (CLK_OUT_EN) m.cc++;
         if (DATA_VALID && m.first_valid < 0) m.first_valid = k;
         step();
         k++;
      end
      m.total = k;
      TOKEN  = 1'b0;
      ENABLE = 1'b1;
      if (rnd_rdy) DATA_READY = 1'b1;
   endtask

   vec_t  tbl[6];
   meas_t m;
   int    base;
   int    nw;
   logic [6:0] acc;

   initial begin
      nRST = 1'b0; ENABLE = 1'b1; TOKEN = 1'b0; DATA = 1'b0; DATA_READY = 1'b1;
      tbl[0] = '{26'h2A55A5A, 32'h12A55A5A};
      tbl[1] = '{26'h0000000, 32'h10000000};
      tbl[2] = '{26'h3FFFFFF, 32'h13FFFFFF};
      tbl[3] = '{26'h1555555, 32'h11555555};
      tbl[4] = '{26'h2AAAAAA, 32'h12AAAAAA};
      tbl[5] = '{26'h3F00001, 32'h13F00001};

      step();
      step();
      nRST = 1'b1;
      mon_on = 1'b1;

      // Reset state
      chk("rst_freeze", 32'(FREEZE), 32'd0);
      chk("rst_read", 32'(READ), 32'd0);
      chk("rst_clken", 32'(CLK_OUT_EN), 32'd0);
      chk("rst_valid", 32'(DATA_VALID), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_dout", DATA_OUT, 32'd0);
      chk("rst_lost", 32'(LOST_CNT), 32'd0);

      // Single-word readouts from the table
      for (int i = 0; i < 6; i++) begin
         words.push_back(tbl[i].hit);
         base = got_q.size();
         measure(1, -1, 1'b0, 200, m);
         chk("tbl_total", 32'(m.total), 32'(ONE_TOTAL));
         chk("tbl_freeze_cyc", 32'(m.fc), 32'(ONE_TOTAL - 1));
         chk("tbl_read_first", 32'(m.first_read), 32'(1 + FS));
         chk("tbl_read_cyc", 32'(m.rc), 32'(RL));
         chk("tbl_clken_cyc", 32'(m.cc), 32'(DB));
         chk("tbl_valid_first", 32'(m.first_valid), 32'(FIRST_CHK));
         chk("tbl_count", 32'(got_q.size() - base), 32'd1);
         if (got_q.size() > base) chk("tbl_word", got_q[base], tbl[i].exp_out);
         chk("tbl_lost", 32'(LOST_CNT), 32'd0);
      end

      // TOKEN held through three words
      for (int i = 0; i < 3; i++) words.push_back(26'(32'h0123456 * (i + 1)));
      base = got_q.size();
      measure(3, -1, 1'b0, 300, m);
      chk("multi_total", 32'(m.total), 32'(ONE_TOTAL + 2 * WORD_CYC));
      chk("multi_freeze_cyc", 32'(m.fc), 32'(ONE_TOTAL - 1 + 2 * WORD_CYC));
      chk("multi_read_pulses", 32'(m.pulses), 32'd3);
      chk("multi_clken_cyc", 32'(m.cc), 32'(3 * DB));
      chk("multi_count", 32'(got_q.size() - base), 32'd3);
      for (int i = 0; i < 3; i++)
         if (got_q.size() > base + i)
            chk("multi_word", got_q[base + i], {ID, 2'b00, 26'(32'h0123456 * (i + 1))});

      // ENABLE dropped in the middle of SHIFT
      words.push_back(26'h1234567);
      base = got_q.size();
      measure(1, 10, 1'b0, 200, m);
      chk("endrop_total", 32'(m.total), 32'(ONE_TOTAL));
      chk("endrop_count", 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) chk("endrop_word", got_q[base], 32'h11234567);

      // ENABLE low with TOKEN high: nothing happens
      ENABLE = 1'b0;
      TOKEN  = 1'b1;
      acc    = '0;
      repeat (20) begin
         acc = acc | {FREEZE, READ, CLK_OUT_EN, BUSY, DATA_VALID, |DATA_OUT, |LOST_CNT};
         step();
      end
      chk("en_off_idle", 32'(acc), 32'd0);
      TOKEN  = 1'b0;
      ENABLE = 1'b1;

      // Backpressure: five words, two buffered, three lost
      DATA_READY = 1'b0;
      for (int i = 0; i < 5; i++) words.push_back(26'(32'h0A00000 + i));
      base = got_q.size();
      measure(5, -1, 1'b0, 400, m);
      chk("bp_total", 32'(m.total), 32'(ONE_TOTAL + 4 * WORD_CYC));
      chk("bp_lost", 32'(LOST_CNT), 32'd3);
      chk("bp_valid", 32'(DATA_VALID), 32'd1);
      DATA_READY = 1'b1;
      repeat (5) step();
      chk("bp_count", 32'(got_q.size() - base), 32'd2);
      for (int i = 0; i < 2; i++)
         if (got_q.size() > base + i)
            chk("bp_word", got_q[base + i], {ID, 2'b00, 26'(32'h0A00000 + i)});
      chk("bp_lost_after", 32'(LOST_CNT), 32'd3);

      // Lost counter saturation
      do_reset();
      DATA_READY = 1'b0;
      for (int i = 0; i < 257; i++) words.push_back(26'($urandom));
      measure(257, -1, 1'b0, 9000, m);
      chk("sat_total", 32'(m.total), 32'(ONE_TOTAL + 256 * WORD_CYC));
      chk("sat_lost_255", 32'(LOST_CNT), 32'd255);
      words.push_back(26'($urandom));
      measure(1, -1, 1'b0, 200, m);
      chk("sat_lost_hold", 32'(LOST_CNT), 32'd255);
      chk("sat_valid", 32'(DATA_VALID), 32'd1);

      // Reset during SHIFT bit 10
      do_reset();
      DATA_READY = 1'b1;
      words.push_back(26'h3C3C3C3);
      base  = got_q.size();
      TOKEN = 1'b1;
      step();
      TOKEN = 1'b0;
      repeat (1 + FS + RL + 10 - 1) step();
      chk("rstmid_shifting", 32'(CLK_OUT_EN), 32'd1);
      nRST = 1'b0;
      step();
      chk("rstmid_freeze", 32'(FREEZE), 32'd0);
      chk("rstmid_read", 32'(READ), 32'd0);
      chk("rstmid_clken", 32'(CLK_OUT_EN), 32'd0);
      chk("rstmid_busy", 32'(BUSY), 32'd0);
      nRST = 1'b1;
      repeat (40) step();
      chk("rstmid_no_word", 32'(got_q.size() - base), 32'd0);
      chk("rstmid_lost", 32'(LOST_CNT), 32'd0);
      words.push_back(26'h2A55A5A);
      base = got_q.size();
      measure(1, -1, 1'b0, 200, m);
      chk("rstmid_clean_total", 32'(m.total), 32'(ONE_TOTAL));
      chk("rstmid_clean_count", 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) chk("rstmid_clean_word", got_q[base], 32'h12A55A5A);

      // Randomized bursts with random backpressure, checked cycle by cycle
      for (int it = 0; it < 12; it++) begin
         nw = $urandom_range(1, 4);
         for (int i = 0; i < nw; i++) words.push_back(26'($urandom));
         measure(nw, -1, 1'b1, 400, m);
         chk("rnd_total", 32'(m.total), 32'(ONE_TOTAL + (nw - 1) * WORD_CYC));
         chk("rnd_pulses", 32'(m.pulses), 32'(nw));
         repeat ($urandom_range(0, 6)) step();
      end
      repeat (4) step();
      chk("rnd_drained", 32'(DATA_VALID), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
